// File: rtl/calc_pkg.sv
// Shared calculator datapath definitions: BCD digit width/limit and operand entry states.
// Used by the operand entry, operand select mux and ALU stages.
package calc_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2
    } entry_state_t;

    function automatic logic is_bcd(input logic [BCD_W-1:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_shift_core.sv
// NDIG-digit BCD shift register with digit count.
// Priority: clr > shift_right > load; loads are ignored when full, shifts when empty.
module bcd_shift_core
    import calc_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int CW   = $clog2(NDIG + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  load,
    input  logic                  shift_right,
    input  logic [BCD_W-1:0]      digit_in,
    output logic [BCD_W*NDIG-1:0] value,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty
);

    localparam int W = BCD_W * NDIG;

    logic [W-1:0]  value_q, value_d;
    logic [CW-1:0] count_q, count_d;

    assign full  = (count_q == CW'(NDIG));
    assign empty = (count_q == '0);

    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (clr) begin
            value_d = '0;
            count_d = '0;
        end else if (shift_right) begin
            if (!empty) begin
                value_d = {{BCD_W{1'b0}}, value_q[W-1:BCD_W]};
                count_d = count_q - 1'b1;
            end
        end else if (load) begin
            if (!full) begin
                value_d = {value_q[W-BCD_W-1:0], digit_in};
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            count_q <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

    assign value = value_q;
    assign count = count_q;

endmodule

// File: rtl/bcd_operand_entry.sv
// Keypad operand entry: shifts BCD digits in at the LS end, commits on enter, hands off downstream.
// Optional backspace support is built when BACKSPACE_EN is defined.
//
// state | meaning
// IDLE  | no digits held
// ENTRY | 1..NDIG digits held, entry open
// HOLD  | operand committed, operand_valid high until downstream takes it
module bcd_operand_entry
    import calc_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BCD_W-1:0]             digit_in,
    input  logic                         digit_valid,
    output logic                         digit_ready,
    input  logic                         clear,
    input  logic                         enter,
`ifdef BACKSPACE_EN
    input  logic                         backspace,
`endif
    output logic [BCD_W*NDIG-1:0]        operand_out,
    output logic [$clog2(NDIG+1)-1:0]    digit_count,
    output logic                         operand_valid,
    input  logic                         operand_ready,
    output logic                         overflow,
    output logic                         bad_digit
);

    localparam int CW = $clog2(NDIG + 1);

    entry_state_t state_q, state_d;
    logic operand_valid_q, operand_valid_d;
    logic overflow_q, overflow_d;
    logic bad_digit_q, bad_digit_d;
    logic core_clr, core_load, core_shift;
    logic core_full, core_empty;
    logic bs_req;

`ifdef BACKSPACE_EN
    assign bs_req = backspace;
`else
    assign bs_req = 1'b0;
`endif

    // Any control request this cycle blocks the digit handshake so the digit is not lost silently.
    assign digit_ready = (state_q != HOLD) & ~clear & ~enter & ~bs_req;

    always_comb begin
        state_d         = state_q;
        operand_valid_d = operand_valid_q;
        overflow_d      = overflow_q;
        bad_digit_d     = 1'b0;
        core_clr        = 1'b0;
        core_load       = 1'b0;
        core_shift      = 1'b0;
        if (state_q == HOLD) begin
            if (operand_valid_q && operand_ready) begin
                core_clr        = 1'b1;
                operand_valid_d = 1'b0;
                overflow_d      = 1'b0;
                state_d         = IDLE;
            end
        end else if (clear) begin
            core_clr   = 1'b1;
            overflow_d = 1'b0;
            state_d    = IDLE;
        end else if (enter) begin
            operand_valid_d = 1'b1;
            state_d         = HOLD;
        end else if (bs_req) begin
            overflow_d = 1'b0;
            if (!core_empty) begin
                core_shift = 1'b1;
                if (digit_count == CW'(1)) begin
                    state_d = IDLE;
                end
            end
        end else if (digit_valid) begin
            if (!is_bcd(digit_in)) begin
                bad_digit_d = 1'b1;
            end else if (core_full) begin
                overflow_d = 1'b1;
            end else begin
                core_load = 1'b1;
                state_d   = ENTRY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            operand_valid_q <= 1'b0;
            overflow_q      <= 1'b0;
            bad_digit_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            operand_valid_q <= operand_valid_d;
            overflow_q      <= overflow_d;
            bad_digit_q     <= bad_digit_d;
        end
    end

    bcd_shift_core #(
        .NDIG (NDIG),
        .CW   (CW)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .clr         (core_clr),
        .load        (core_load),
        .shift_right (core_shift),
        .digit_in    (digit_in),
        .value       (operand_out),
        .count       (digit_count),
        .full        (core_full),
        .empty       (core_empty)
    );

    assign operand_valid = operand_valid_q;
    assign overflow      = overflow_q;
    assign bad_digit     = bad_digit_q;

endmodule
